// File: rtl/alu_pkg.sv
// Shared ALU op encodings and sequencer state for the bit-serial ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_PASS_B, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bit_slice.sv
// One-bit ALU slice: full adder with B inversion for subtract, plus logic ops.
module bit_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carry_i,
    input  logic       sub_i,
    input  logic [2:0] op_i,
    output logic       result_o,
    output logic       carry_o
);
    logic bx;

    assign bx      = b_i ^ sub_i;
    assign carry_o = (a_i & bx) | (carry_i & (a_i ^ bx));

    always_comb begin
        result_o = 1'b0;
        case (op_i)
            OP_PASS_B:      result_o = b_i;
            OP_ADD, OP_SUB: result_o = a_i ^ bx ^ carry_i;
            OP_AND:         result_o = a_i & b_i;
            OP_OR:          result_o = a_i | b_i;
            OP_XOR:         result_o = a_i ^ b_i;
            default:        result_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU: feeds captured operands LSB-first through one bit_slice,
// assembling the result and N/Z/C/V flags over WIDTH cycles.
module alu_serial_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, result_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             n_q, z_q, c_q, v_q;
    logic             accept, last;
    logic             sub, arith, slice_res, slice_cout, res_bit;
    logic [WIDTH-1:0] result_next;

    assign sub         = (op_q == OP_SUB);
    assign arith       = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign last        = (count_q == LAST);
    assign res_bit     = is_legal_op(op_q) ? slice_res : 1'b0;
    assign result_next = {res_bit, result_q[WIDTH-1:1]};

    bit_slice u_slice (
        .a_i      (a_sh_q[0]),
        .b_i      (b_sh_q[0]),
        .carry_i  (carry_q),
        .sub_i    (sub),
        .op_i     (op_q),
        .result_o (slice_res),
        .carry_o  (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (start) begin state_d = RUN; accept = 1'b1; end
            RUN:  if (last)  state_d = DONE;
            DONE: begin
                state_d = start ? RUN : IDLE;
                accept  = start;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            {n_q, z_q, c_q, v_q} <= '0;
        end else if (accept) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            op_q    <= cntrl;
            count_q <= '0;
            carry_q <= (cntrl == OP_SUB);
        end else if (state_q == RUN) begin
            a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
            result_q <= result_next;
            carry_q  <= slice_cout;
            count_q  <= last ? '0 : count_q + 1'b1;
            if (last) begin
                // carry_q here is the carry into the MSB, so V = cin(msb) ^ cout(msb)
                n_q <= res_bit;
                z_q <= (result_next == '0);
                c_q <= arith & slice_cout;
                v_q <= arith & (carry_q ^ slice_cout);
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_v = v_q;
endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
- Bit-serial ALU front/back end. Captures full-width operands and an ALU control code, then feeds one bit per cycle, LSB first, into a single bit_slice instance.
- Chains the slice carry through a flop and shifts the slice result into a result register.
- Produces registered result plus N/Z/C/V flags with a start/busy/done handshake.
- Sits between the decode/register-read stage and the flag/writeback logic as the area-minimal ALU option.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op_a  input  WIDTH  operand A, captured on accepted start.
- op_b  input  WIDTH  operand B, captured on accepted start.
- cntrl  input  3  ALU op, captured on accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  registered result.
- flag_n  output  1  negative flag.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry flag.
- flag_v  output  1  overflow flag.

Behaviour:
- Reset is asynchronous on rst_n low. State goes to IDLE. busy=0, done=0, result=0, all flags=0. Operand and carry registers are cleared.
- cntrl encoding:
  - 000 pass B
  - 010 add
  - 011 subtract
  - 100 and
  - 101 or
  - 110 xor
  - 001 and 111 are illegal: the slice output is ignored and the result bit shifted in is 0.
- Slice drive: subtract = (cntrl == 011). Carry flop initial value = subtract (the +1 of two's complement).
- FSM:
  - IDLE: on start, capture op_a, op_b, cntrl; count=0; carry=subtract; go to RUN.
  - RUN (exactly WIDTH cycles): slice inputs are A=a_sh[0], B=b_sh[0], carry_in=carry_q. Each edge:
    - result shifts right, slice result enters at the MSB;
    - a_sh and b_sh shift right;
    - carry_q <= carry_out;
    - count++.
  - When count == WIDTH-1 on the edge, go to DONE. On that same edge, latch c_into_msb = carry_q (the slice carry_in for bit WIDTH-1).
  - DONE (1 cycle): done=1 and flags are valid. start in DONE is accepted exactly as in IDLE (back-to-back, next state RUN). Otherwise go to IDLE.
- Latency: start accepted at edge k. busy is high cycles k+1..k+WIDTH. done is high in cycle k+WIDTH+1.
- result and flags hold their values from DONE until the next accepted start. They are not cleared on entering RUN; they update only as the shift register fills.
- Flags are registered on the RUN->DONE edge:
  - flag_n = final result[WIDTH-1].
  - flag_z = (final result == 0).
  - flag_c = final carry_out for add/sub, else 0.
  - flag_v = c_into_msb XOR final carry_out for add/sub, else 0.
- start while busy is ignored: no capture, no error, and no effect on the current operation.
- Input changes on op_a/op_b/cntrl during RUN are ignored (captured copies are used).
- Reset mid-RUN aborts immediately to IDLE with the reset values above. No done pulse is produced.
- Count wraps only via the DONE transition and never exceeds WIDTH-1.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t, 3-bit enum with OP_PASS_B=3'b000, OP_ADD=3'b010, OP_SUB=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110;
  - function is_legal_op;
  - typedef seq_state_t {IDLE, RUN, DONE}.
- One sub-module: the existing bit_slice, instantiated once and unmodified.
- FSM, shift registers, counter and flag logic live in alu_serial_sequencer.

Test Plan (WIDTH=8 override):
- ADD 0x7F + 0x01, start one cycle -> busy for 8 cycles, done in cycle 9 after accept; result=0x80, N=1 Z=0 C=0 V=1.
- SUB 0x05 - 0x05 -> result=0x00, Z=1 C=1 N=0 V=0. SUB 0x00 - 0x01 -> result=0xFF, N=1 C=0 V=0.
- AND/OR/XOR/PASS_B with A=0xCA, B=0x5C -> 0x48 / 0xDE / 0x96 / 0x5C respectively; C=V=0 for all; Z=0.
- Illegal cntrl 3'b111, A=0xFF, B=0xFF -> after 8 busy cycles result=0x00, Z=1, N=C=V=0.
- Back-to-back: start held high through DONE of ADD 0x01+0x01 (captured operands: ADD 0x02+0x03) -> first done result=0x02, second op accepted in DONE with no IDLE cycle, second done result=0x05. start pulses during RUN are ignored.
- Reset mid-op: assert rst_n=0 asynchronously at RUN count=4 -> busy, done, result and flags go to 0 immediately. After release, a fresh ADD 0x10+0x20 gives 0x30.
